// File: rtl/vector_ping_pong_sched.sv
// Iteration scheduler for a ping-pong vector RAM pair: sweeps read addresses over x, waits for
// all x reads and x_n writes to retire, then pings the pair to swap banks for the next pass.
module vector_ping_pong_sched #(
    parameter int unsigned LENGTH      = 32,
    parameter int unsigned PARALLELISM = 4,
    parameter int unsigned ITER_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ITER_WIDTH-1:0]              num_iters,
    output logic                               busy,
    output logic                               done,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [PARALLELISM*$clog2(LENGTH)-1:0] rd_addr,
    input  logic                               rd_resp,
    input  logic                               wr_beat,
    output logic                               ping,
    output logic [ITER_WIDTH-1:0]              iter,
    output logic                               err
);

    localparam int unsigned ADDR_WIDTH = $clog2(LENGTH);
    localparam int unsigned BEATS      = LENGTH / PARALLELISM;
    localparam int unsigned CNT_WIDTH  = $clog2(BEATS + 1);

    localparam logic [CNT_WIDTH-1:0] BeatsCnt = CNT_WIDTH'(BEATS);
    localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StSwap, StSettle} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]  rresp_cnt_q, rresp_cnt_d;
    logic [CNT_WIDTH-1:0]  wbeat_cnt_q, wbeat_cnt_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [ITER_WIDTH-1:0] num_iters_q, num_iters_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  last_iter;

    assign last_iter = (iter_q == num_iters_q - ITER_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            rresp_cnt_q <= '0;
            wbeat_cnt_q <= '0;
            iter_q      <= '0;
            num_iters_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            rresp_cnt_q <= rresp_cnt_d;
            wbeat_cnt_q <= wbeat_cnt_d;
            iter_q      <= iter_d;
            num_iters_q <= num_iters_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Counters, iteration bookkeeping and sticky overflow detection.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        rresp_cnt_d = rresp_cnt_q;
        wbeat_cnt_d = wbeat_cnt_q;
        iter_d      = iter_q;
        num_iters_d = num_iters_q;
        done_d      = 1'b0;
        err_d       = err_q;

        if (state_q == StIssue || state_q == StDrain) begin
            if (rd_resp) begin
                if (rresp_cnt_q == BeatsCnt) err_d = 1'b1;
                else rresp_cnt_d = rresp_cnt_q + CNT_WIDTH'(1);
            end
            if (wr_beat) begin
                if (wbeat_cnt_q == BeatsCnt) err_d = 1'b1;
                else wbeat_cnt_d = wbeat_cnt_q + CNT_WIDTH'(1);
            end
        end else if (rd_resp || wr_beat) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_iters_d = num_iters;
                    iter_d      = '0;
                    beat_cnt_d  = '0;
                    rresp_cnt_d = '0;
                    wbeat_cnt_d = '0;
                    done_d      = (num_iters == '0);
                end
            end
            StIssue: begin
                if (rd_ready && beat_cnt_q != BeatsCnt) beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            end
            StSwap: begin
                beat_cnt_d  = '0;
                rresp_cnt_d = '0;
                wbeat_cnt_d = '0;
            end
            StSettle: begin
                if (last_iter) done_d = 1'b1;
                else iter_d = iter_q + ITER_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start && num_iters != '0) state_d = StIssue;
            StIssue:  if (rd_ready && beat_cnt_q == LastBeat) state_d = StDrain;
            // Use the post-update counts so a final beat arriving now is not missed.
            StDrain:  if (rresp_cnt_d == BeatsCnt && wbeat_cnt_d == BeatsCnt) state_d = StSwap;
            StSwap:   state_d = StSettle;
            StSettle: state_d = last_iter ? StIdle : StIssue;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        rd_valid = (state_q == StIssue);
        ping     = (state_q == StSwap);
        done     = done_q;
        err      = err_q;
        iter     = iter_q;
        rd_addr  = '0;
        if (state_q == StIssue) begin
            for (int i = 0; i < int'(PARALLELISM); i++) begin
                rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    ADDR_WIDTH'(int'(beat_cnt_q) * int'(PARALLELISM) + i);
            end
        end
    end

endmodule
